ex_hilo_unit: RTL

//  - Multi-cycle HI/LO arithmetic unit inside the EX stage. Executes MULT/MULTU,

---
 rtl/ex_hilo_unit_pkg.sv | 27 ++
 rtl/ex_hilo_unit_div_iter.sv | 43 ++++
 rtl/ex_hilo_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/ex_hilo_unit_pkg.sv
// ex_hilo_unit_pkg: HI/LO unit op codes, FSM states and op-class helpers.
package ex_hilo_unit_pkg;
  localparam logic [2:0] HILO_MULT  = 3'd0;
  localparam logic [2:0] HILO_MULTU = 3'd1;
  localparam logic [2:0] HILO_MADD  = 3'd2;
  localparam logic [2:0] HILO_MADDU = 3'd3;
  localparam logic [2:0] HILO_MSUB  = 3'd4;
  localparam logic [2:0] HILO_MSUBU = 3'd5;
  localparam logic [2:0] HILO_DIV   = 3'd6;
  localparam logic [2:0] HILO_DIVU  = 3'd7;
  typedef enum logic [1:0] {IDLE, MAC2, DIV_ON, DIV_END} hilo_state_e;
  function automatic logic op_signed(input logic [2:0] op);
    return op == HILO_MULT || op == HILO_MADD || op == HILO_MSUB || op == HILO_DIV;
  endfunction
  function automatic logic op_mul(input logic [2:0] op);
    return op == HILO_MULT || op == HILO_MULTU;
  endfunction
  function automatic logic op_mac(input logic [2:0] op);
    return op == HILO_MADD || op == HILO_MADDU || op == HILO_MSUB || op == HILO_MSUBU;
  endfunction
  function automatic logic op_sub(input logic [2:0] op);
    return op == HILO_MSUB || op == HILO_MSUBU;
  endfunction
  function automatic logic op_div(input logic [2:0] op);
    return op == HILO_DIV || op == HILO_DIVU;
  endfunction
endpackage

// File: rtl/ex_hilo_unit_div_iter.sv
// ex_hilo_unit_div_iter: radix-2 restoring divider core on unsigned magnitudes, one bit per step.
module ex_hilo_unit_div_iter #(
  parameter int DW = 32,
  parameter int CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem,
  output logic [CW-1:0] cnt,
  output logic          done
);
  logic [DW-1:0] div_r;
  logic [DW:0] shifted, diff;
  logic fits;
  always_comb begin
    shifted = {rem, quo[DW-1]};
    diff = shifted - {1'b0, div_r};
    fits = ~diff[DW];
    done = step && cnt == CW'(DW - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      div_r <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      div_r <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= fits ? diff[DW-1:0] : shifted[DW-1:0];
      quo <= {quo[DW-2:0], fits};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ex_hilo_unit.sv
// ex_hilo_unit: EX-stage HI/LO unit; single-cycle MULT, two-cycle MADD/MSUB, iterative DIV.
module ex_hilo_unit
  import ex_hilo_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [DW-1:0]  opnd1,
  input  logic [DW-1:0]  opnd2,
  input  logic [DW-1:0]  hi_in,
  input  logic [DW-1:0]  lo_in,
  input  logic           annul,
  output logic           stallreq,
  output logic           hilo_we,
  output logic [DW-1:0]  hi_out,
  output logic [DW-1:0]  lo_out,
  output logic           busy
);
  localparam int CW = $clog2(DW);
  hilo_state_e state;
  logic [2*DW-1:0] prod_r, product, acc, a_ext, b_ext;
  logic [DW-1:0] a_mag, b_mag, quo, rem, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic sub_r, neg_q, neg_r, a_neg, b_neg, b_zero, sgn, live, idle_go, div_done;
  logic is_mul, is_mac, is_div;
  always_comb begin
    sgn = op_signed(3'(op));
    is_mul = op_mul(3'(op));
    is_mac = op_mac(3'(op));
    is_div = op_div(3'(op));
    a_neg = sgn & opnd1[DW-1];
    b_neg = sgn & opnd2[DW-1];
    b_zero = opnd2 == '0;
    a_mag = a_neg ? -opnd1 : opnd1;
    b_mag = b_neg ? -opnd2 : opnd2;
    a_ext = {{DW{a_neg}}, opnd1};
    b_ext = {{DW{b_neg}}, opnd2};
    product = a_ext * b_ext;
    acc = sub_r ? {hi_in, lo_in} - prod_r : {hi_in, lo_in} + prod_r;
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem : rem;
    live = ~rst & ~annul;
    idle_go = live & start & state == IDLE;
    hilo_we = (idle_go & is_mul) | (live & (state == MAC2 || state == DIV_END));
    stallreq = (idle_go & (is_mac | is_div)) | (live & state == DIV_ON);
    {hi_out, lo_out} = !hilo_we ? '0 : state == MAC2 ? acc : state == DIV_END ? {r_fix, q_fix} : product;
    busy = ~rst & state != IDLE;
  end
  // A zero divisor loads 0/0 so the core already holds the required quo=rem=0.
  ex_hilo_unit_div_iter #(.DW(DW), .CW(CW)) u_div (
    .clk(clk),
    .rst(rst),
    .load(idle_go & is_div),
    .step(live & state == DIV_ON),
    .dividend(b_zero ? '0 : a_mag),
    .divisor(b_zero ? '0 : b_mag),
    .quo(quo),
    .rem(rem),
    .cnt(cnt),
    .done(div_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prod_r <= '0;
      sub_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (annul) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && is_mac) begin
            prod_r <= product;
            sub_r <= op_sub(3'(op));
            state <= MAC2;
          end else if (start && is_div) begin
            neg_q <= ~b_zero & (a_neg ^ b_neg);
            neg_r <= ~b_zero & a_neg;
            state <= b_zero ? DIV_END : DIV_ON;
          end
        end
        MAC2: state <= IDLE;
        DIV_ON: state <= div_done ? DIV_END : DIV_ON;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
